cache_miss_ctrl: RTL and testbench

CACHE_MISS_CTRL -- requirements
Module: cache_miss_ctrl

---
 rtl/cache_miss_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cache_miss_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
// Direct-mapped, 16-line, one-word-per-line cache controller. Read hits are
// answered in the same cycle. Read misses refill the line from memory. Writes
// are write-through and write-allocate. Hit and miss counters saturate.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   req, ALU_Out, DataW, RW: CPU access (held stable by the CPU while stall=1)
//   DataR, stall           : load data and CPU stall
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ack/mem_rdata : memory handshake
//   hit_cnt, miss_cnt      : saturating access statistics
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module cache_miss_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [31:0]      ALU_Out,
  input  logic [31:0]      DataW,
  input  logic             RW,
  output logic [31:0]      DataR,
  output logic             stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ_MEM  = 2'd1;
  localparam logic [1:0] WRITE_MEM = 2'd2;
  localparam logic [1:0] DONE      = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [15:0]      valid_r;
  logic [25:0]      tag_r  [16];
  logic [31:0]      data_r [16];
  logic [29:0]      addr_r;     // word address latched when leaving IDLE
  logic [31:0]      wdata_r;    // store data latched when leaving IDLE
  logic [31:0]      result_r;
  logic [CNT_W-1:0] hit_cnt_r;
  logic [CNT_W-1:0] miss_cnt_r;

  logic [3:0]       idx_s;
  logic [25:0]      tag_s;
  logic             hit_s;
  logic [3:0]       fill_idx_s;
  logic             fill_s;
  logic             unused_s;

  assign idx_s      = ALU_Out[5:2];
  assign tag_s      = ALU_Out[31:6];
  assign hit_s      = req & valid_r[idx_s] & (tag_r[idx_s] == tag_s);
  assign fill_idx_s = addr_r[3:0];
  // Line update happens only on the ack cycle and never while reset is applied.
  assign fill_s     = ~rst & mem_ack & ((state_r == READ_MEM) | (state_r == WRITE_MEM));
  assign unused_s   = ^ALU_Out[1:0];

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;

  // Control state, valid bits, latched request, result and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      valid_r    <= 16'h0000;
      addr_r     <= 30'd0;
      wdata_r    <= 32'h0000_0000;
      result_r   <= 32'h0000_0000;
      hit_cnt_r  <= {CNT_W{1'b0}};
      miss_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            if (hit_s) begin
              if (hit_cnt_r != CNT_MAX) hit_cnt_r <= hit_cnt_r + CNT_ONE;
            end else begin
              if (miss_cnt_r != CNT_MAX) miss_cnt_r <= miss_cnt_r + CNT_ONE;
            end
            if (RW | ~hit_s) begin
              addr_r  <= ALU_Out[31:2];
              wdata_r <= DataW;
              state_r <= RW ? WRITE_MEM : READ_MEM;
            end
          end
        end
        READ_MEM: begin
          if (mem_ack) begin
            valid_r[fill_idx_s] <= 1'b1;
            result_r            <= mem_rdata;
            state_r             <= DONE;
          end
        end
        WRITE_MEM: begin
          if (mem_ack) begin
            valid_r[fill_idx_s] <= 1'b1;
            result_r            <= wdata_r;
            state_r             <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Line tag/data storage; written only on an accepted memory ack.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_r[fill_idx_s]  <= addr_r[29:4];
      data_r[fill_idx_s] <= (state_r == WRITE_MEM) ? wdata_r : mem_rdata;
    end
  end

  // CPU-side and memory-side outputs decoded from the current state.
  always_comb begin
    DataR     = 32'h0000_0000;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (req) begin
          stall = RW | ~hit_s;
          if (hit_s & ~RW) begin
            DataR = data_r[idx_s];
          end else begin
            DataR = 32'h0000_0000;
          end
        end else begin
          stall = 1'b0;
        end
      end
      READ_MEM: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_r, 2'b00};
      end
      WRITE_MEM: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_r, 2'b00};
        mem_wdata = wdata_r;
      end
      DONE: begin
        DataR = result_r;
      end
      default: begin
        DataR = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_miss_ctrl
// Self-checking bench: directed scenarios plus randomized accesses compared
// against a line-level cache model and a word-addressed memory model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] ALU_Out;
  logic [31:0] DataW;
  logic        RW;
  logic [31:0] DataR;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: cache lines, backing memory, access counts.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem     [logic [31:0]];
  int          m_hits;
  int          m_misses;

  always #5 clk = ~clk;

  cache_miss_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .ALU_Out(ALU_Out), .DataW(DataW),
    .RW(RW), .DataR(DataR), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int n);
    return (n > 65535) ? 32'd65535 : n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic check_counters(input string where);
    check({where, "_hit_cnt"},  {16'h0, hit_cnt},  sat(m_hits));
    check({where, "_miss_cnt"}, {16'h0, miss_cnt}, sat(m_misses));
  endtask

  // One complete CPU access with a memory response after lat extra cycles.
  task automatic access(input logic [31:0] addr, input logic rw,
                        input logic [31:0] wd, input int lat);
    logic [3:0]  idx;
    logic [25:0] tg;
    logic [31:0] al;
    logic [31:0] exp_res;
    bit          hit;
    idx = addr[5:2];
    tg  = addr[31:6];
    al  = {addr[31:2], 2'b00};
    @(negedge clk);
    req = 1'b0; mem_ack = 1'b0; #1;
    check("idle_stall", {31'h0, stall}, 32'h0);
    check("idle_datar", DataR, 32'h0);
    check("idle_mem_req", {31'h0, mem_req}, 32'h0);
    check_counters("idle");
    req = 1'b1; ALU_Out = addr; RW = rw; DataW = wd; #1;
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) m_hits++; else m_misses++;
    if (!rw && hit) begin
      check("hit_stall", {31'h0, stall}, 32'h0);
      check("hit_datar", DataR, m_data[idx]);
      check("hit_mem_req", {31'h0, mem_req}, 32'h0);
    end else begin
      exp_res = 32'h0;
      check("lookup_stall", {31'h0, stall}, 32'h1);
      check("lookup_mem_req", {31'h0, mem_req}, 32'h0);
      for (int c = 0; c <= lat; c++) begin
        @(negedge clk); #1;
        check("mem_stall", {31'h0, stall}, 32'h1);
        check("mem_req", {31'h0, mem_req}, 32'h1);
        check("mem_we", {31'h0, mem_we}, {31'h0, rw});
        check("mem_addr", mem_addr, al);
        if (rw) check("mem_wdata", mem_wdata, wd);
        if (c == lat) begin
          if (rw) begin
            mem[al]   = wd;
            exp_res   = wd;
            mem_rdata = $urandom;
          end else begin
            if (!mem.exists(al)) mem[al] = $urandom;
            exp_res   = mem[al];
            mem_rdata = mem[al];
          end
          mem_ack = 1'b1;
        end
      end
      // A stray ack in the DONE cycle must be ignored.
      @(negedge clk);
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; #1;
      check("done_stall", {31'h0, stall}, 32'h0);
      check("done_datar", DataR, exp_res);
      check("done_mem_req", {31'h0, mem_req}, 32'h0);
      check_counters("done");
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = exp_res;
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; ALU_Out = 32'h0; DataW = 32'h0; RW = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; #1;
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_datar", DataR, 32'h0);
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check_counters("rst");

    // Directed scenarios.
    mem[32'h40] = 32'hDEAD_BEEF;
    access(32'h0000_0040, 1'b0, 32'h0, 3);
    check("first_miss_cnt", {16'h0, miss_cnt}, 32'd1);
    access(32'h0000_0040, 1'b0, 32'h0, 0);
    access(32'h0000_0044, 1'b1, 32'h1234_5678, 2);
    access(32'h0000_0044, 1'b0, 32'h0, 0);
    access(32'h0000_0080, 1'b0, 32'h0, 1);
    access(32'h0000_0040, 1'b0, 32'h0, 1);

    // Saturation: a hit every cycle for more than 65536 cycles.
    @(negedge clk);
    req = 1'b1; RW = 1'b0; ALU_Out = 32'h0000_0044; #1;
    check("sat_hit_datar", DataR, 32'h1234_5678);
    repeat (65540) @(posedge clk);
    m_hits += 65540;
    @(negedge clk);
    req = 1'b0; #1;
    check("sat_hit_cnt", {16'h0, hit_cnt}, 32'h0000_FFFF);
    check_counters("sat");

    // Reset in READ_MEM with a coincident ack.
    @(negedge clk);
    req = 1'b1; RW = 1'b0; ALU_Out = 32'h0000_00C0;
    @(negedge clk); #1;
    check("rstmid_mem_req_before", {31'h0, mem_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0; req = 1'b0;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0; #1;
    model_reset();
    check("rstmid_mem_req", {31'h0, mem_req}, 32'h0);
    check("rstmid_stall", {31'h0, stall}, 32'h0);
    check_counters("rstmid");
    access(32'h0000_0040, 1'b0, 32'h0, 1);
    check("rstmid_refetch_miss", {16'h0, miss_cnt}, 32'd1);
    access(32'h0000_00C0, 1'b0, 32'h0, 0);

    // Randomized accesses over a small address pool to mix hits and misses.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      access(a, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end
    @(negedge clk);
    req = 1'b0; mem_ack = 1'b0; #1;
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
